// File: rtl/chart_sequencer.sv
// Chart sequencer: steps a combinational chart ROM once per step period
// and emits each entry as a registered note with a one-cycle strobe.
// Ports: clk_i, reset_n_i (sync active-low), start_i/pause_i/abort_i
// controls, rom_addr_o/rom_data_i ROM port, note_o/note_valid_o output
// note, busy_o (RUN or PAUSE), done_o (DONE).
// Optional macro CHART_SEQUENCER_LOOP_EN: wrap to entry 0 at chart end
// instead of stopping.
module chart_sequencer #(
  parameter int width_p          = 8,
  parameter int depth_p          = 8,
  parameter int ticks_per_step_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic                       pause_i,
  input  logic                       abort_i,
  output logic [$clog2(depth_p)-1:0] rom_addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic [width_p-1:0]         note_o,
  output logic                       note_valid_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int aw = $clog2(depth_p);
  localparam int cw =
    (ticks_per_step_p > 1) ? $clog2(ticks_per_step_p) : 1;
  localparam logic [aw-1:0] last_addr = aw'(depth_p - 1);
  localparam logic [cw-1:0] last_tick = cw'(ticks_per_step_p - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t               state, state_n;
  logic [cw-1:0]        cnt, cnt_n;
  logic [aw-1:0]        addr_n;
  logic [width_p-1:0]   note_n;
  logic                 valid_n;
  logic                 busy_n;
  logic                 done_n;
  logic                 end_mark;

  assign end_mark = &rom_data_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state        <= IDLE;
      cnt          <= '0;
      rom_addr_o   <= '0;
      note_o       <= '0;
      note_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      rom_addr_o   <= addr_n;
      note_o       <= note_n;
      note_valid_o <= valid_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = rom_addr_o;
    note_n  = note_o;
    valid_n = 1'b0;
    if (abort_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      addr_n  = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i && !pause_i) begin
            state_n = RUN;
            cnt_n   = '0;
            addr_n  = '0;
          end
        end
        RUN, PAUSE: begin
          // A low pause_i in PAUSE counts as a RUN cycle, so the
          // resume edge itself advances the frozen counter.
          if (pause_i) begin
            state_n = PAUSE;
          end else begin
            state_n = RUN;
            if (cnt != last_tick) begin
              cnt_n = cnt + cw'(1);
            end else begin
              cnt_n = '0;
`ifdef CHART_SEQUENCER_LOOP_EN
              if (end_mark) begin
                // Marker at entry 0 means an empty chart.
                if (rom_addr_o == '0) state_n = DONE;
                else addr_n = '0;
              end else begin
                note_n  = rom_data_i;
                valid_n = 1'b1;
                addr_n  = (rom_addr_o == last_addr) ?
                          '0 : rom_addr_o + aw'(1);
              end
`else
              if (end_mark) begin
                state_n = DONE;
              end else begin
                note_n  = rom_data_i;
                valid_n = 1'b1;
                if (rom_addr_o == last_addr) state_n = DONE;
                else addr_n = rom_addr_o + aw'(1);
              end
`endif
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n == RUN) || (state_n == PAUSE);
    done_n = (state_n == DONE);
  end

endmodule
